// File: rtl/axil_mmio_master_pkg.sv
// axil_mmio_master_pkg: shared FSM states, AXI response codes and size helpers
package axil_mmio_master_pkg;
  typedef enum logic [1:0] {IDLE, SEND, RESP, DONE} axil_mmio_state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    return size == 2'd0 ? 4'h1 : size == 2'd1 ? 4'h3 : 4'hF;
  endfunction
endpackage

// File: rtl/axil_mmio_lane_align.sv
// axil_mmio_lane_align: write-lane replication/strobes and read-lane extraction
module axil_mmio_lane_align
  import axil_mmio_master_pkg::*;
#(
  parameter int data_width_p = 32
) (
  input  logic [1:0]                  addr_lo,
  input  logic [1:0]                  size,
  input  logic [data_width_p-1:0]     wdata_in,
  input  logic [data_width_p-1:0]     rdata_in,
  output logic [data_width_p-1:0]     wdata_out,
  output logic [data_width_p/8-1:0]   wstrb,
  output logic [data_width_p-1:0]     rdata_out
);
  logic [data_width_p-1:0] shifted;
  always_comb begin
    wdata_out = size == 2'd0 ? {(data_width_p/8){wdata_in[7:0]}}
              : size == 2'd1 ? {(data_width_p/16){wdata_in[15:0]}} : wdata_in;
    wstrb = (data_width_p/8)'(size_mask(size)) << addr_lo;
    shifted = rdata_in >> {addr_lo, 3'b000};
    rdata_out = size == 2'd0 ? data_width_p'(shifted[7:0])
              : size == 2'd1 ? data_width_p'(shifted[15:0]) : shifted;
  end
endmodule

// File: rtl/axil_mmio_master.sv
// axil_mmio_master: single-outstanding MMIO request to AXI4-Lite master.
// Optional response timeout with AXIL_MMIO_MASTER_TIMEOUT_EN.
module axil_mmio_master
  import axil_mmio_master_pkg::*;
#(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  parameter int timeout_cycles_p  = 1024
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_and_o,
  input  logic [axil_addr_width_p-1:0]   addr_i,
  input  logic                           wr_en_i,
  input  logic [1:0]                     data_size_i,
  input  logic [axil_data_width_p-1:0]   wdata_i,
  output logic                           v_o,
  input  logic                           ready_and_i,
  output logic [axil_data_width_p-1:0]   rdata_o,
  output logic                           err_o,
  output logic [axil_addr_width_p-1:0]   m_axil_awaddr,
  output logic [2:0]                     m_axil_awprot,
  output logic                           m_axil_awvalid,
  input  logic                           m_axil_awready_i,
  output logic [axil_data_width_p-1:0]   m_axil_wdata,
  output logic [axil_data_width_p/8-1:0] m_axil_wstrb,
  output logic                           m_axil_wvalid,
  input  logic                           m_axil_wready_i,
  input  logic [1:0]                     m_axil_bresp,
  input  logic                           m_axil_bvalid,
  output logic                           m_axil_bready_o,
  output logic [axil_addr_width_p-1:0]   m_axil_araddr,
  output logic [2:0]                     m_axil_arprot,
  output logic                           m_axil_arvalid,
  input  logic                           m_axil_arready_i,
  input  logic [axil_data_width_p-1:0]   m_axil_rdata,
  input  logic [1:0]                     m_axil_rresp,
  input  logic                           m_axil_rvalid,
  output logic                           m_axil_rready_o
);
  axil_mmio_state_e state_r, state_n;
  logic [axil_addr_width_p-1:0] addr_r;
  logic [axil_data_width_p-1:0] wdata_r, rdata_r, rdata_al;
  logic [1:0] size_r;
  logic [3:0] in_mask;
  logic wr_r, aw_done_r, w_done_r, err_r;
  logic accept, bad, aw_hs, w_hs, ar_hs, resp_hs, timeout, stale;
  assign in_mask = size_mask(data_size_i);
  assign bad = data_size_i == 2'd3 || |(addr_i[1:0] & in_mask[2:1]);
  assign ready_and_o = state_r == IDLE && !reset_i && !stale;
  assign accept = v_i && ready_and_o;
  assign m_axil_awaddr = addr_r;
  assign m_axil_araddr = addr_r;
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign m_axil_awvalid = state_r == SEND && wr_r && !aw_done_r;
  assign m_axil_wvalid = state_r == SEND && wr_r && !w_done_r;
  assign m_axil_arvalid = state_r == SEND && !wr_r;
  assign m_axil_bready_o = (state_r == RESP && wr_r) || stale;
  assign m_axil_rready_o = (state_r == RESP && !wr_r) || stale;
  assign aw_hs = m_axil_awvalid && m_axil_awready_i;
  assign w_hs = m_axil_wvalid && m_axil_wready_i;
  assign ar_hs = m_axil_arvalid && m_axil_arready_i;
  assign resp_hs = state_r == RESP && (wr_r ? m_axil_bvalid : m_axil_rvalid);
  assign v_o = state_r == DONE;
  assign rdata_o = rdata_r;
  assign err_o = err_r;
  axil_mmio_lane_align #(.data_width_p(axil_data_width_p)) align (
    .addr_lo(addr_r[1:0]),
    .size(size_r),
    .wdata_in(wdata_r),
    .rdata_in(m_axil_rdata),
    .wdata_out(m_axil_wdata),
    .wstrb(m_axil_wstrb),
    .rdata_out(rdata_al)
  );
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: state_n = accept ? (bad ? DONE : SEND) : IDLE;
      SEND: state_n = (wr_r ? (aw_done_r || aw_hs) && (w_done_r || w_hs) : ar_hs) ? RESP : SEND;
      RESP: state_n = resp_hs || timeout ? DONE : RESP;
      DONE: state_n = ready_and_i ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      addr_r <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      size_r <= 2'd0;
      wr_r <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        addr_r <= addr_i;
        wdata_r <= wdata_i;
        size_r <= data_size_i;
        wr_r <= wr_en_i;
        aw_done_r <= 1'b0;
        w_done_r <= 1'b0;
        err_r <= bad;
        rdata_r <= '0;
      end
      if (aw_hs) aw_done_r <= 1'b1;
      if (w_hs) w_done_r <= 1'b1;
      if (resp_hs) begin
        err_r <= (wr_r ? m_axil_bresp : m_axil_rresp) >= RESP_SLVERR;
        rdata_r <= wr_r ? '0 : rdata_al;
      end else if (timeout) err_r <= 1'b1;
    end
  end
`ifdef AXIL_MMIO_MASTER_TIMEOUT_EN
  localparam int cw = $clog2(timeout_cycles_p + 1);
  logic [cw-1:0] cnt_r;
  logic stale_r;
  assign timeout = state_r == RESP && !resp_hs && cnt_r == cw'(timeout_cycles_p - 1);
  assign stale = stale_r;
  // A late B/R after a timeout is swallowed here so it never reaches a new request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r <= '0;
      stale_r <= 1'b0;
    end else begin
      cnt_r <= state_r == RESP ? cnt_r + cw'(1) : '0;
      if (timeout) stale_r <= 1'b1;
      else if (stale_r && (m_axil_bvalid || m_axil_rvalid)) stale_r <= 1'b0;
    end
  end
`else
  localparam int unused_timeout_p = timeout_cycles_p;
  assign timeout = 1'b0;
  assign stale = 1'b0;
`endif
endmodule

// File: tb/tb_axil_mmio_master.sv
// tb_axil_mmio_master: table-driven directed bench with a scripted AXI-Lite slave
module tb_axil_mmio_master;
  logic clk = 0, reset_i = 1, v_i = 0, wr_en_i = 0, ready_and_i = 1;
  logic ready_and_o, v_o, err_o;
  logic [31:0] addr_i = 0, wdata_i = 0, rdata_o;
  logic [1:0] data_size_i = 0;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata = 0;
  logic [2:0] m_axil_awprot, m_axil_arprot;
  logic [3:0] m_axil_wstrb;
  logic m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready_o, m_axil_rready_o;
  logic m_axil_awready_i = 0, m_axil_wready_i = 0, m_axil_arready_i = 0;
  logic m_axil_bvalid = 0, m_axil_rvalid = 0;
  logic [1:0] m_axil_bresp = 0, m_axil_rresp = 0;
  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  axil_mmio_master #(.timeout_cycles_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_and_o(ready_and_o),
    .addr_i(addr_i), .wr_en_i(wr_en_i), .data_size_i(data_size_i), .wdata_i(wdata_i),
    .v_o(v_o), .ready_and_i(ready_and_i), .rdata_o(rdata_o), .err_o(err_o),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready_i(m_axil_awready_i),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready_i(m_axil_wready_i),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready_o(m_axil_bready_o),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready_i(m_axil_arready_i),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready_o(m_axil_rready_o)
  );

  typedef struct {
    logic wr; logic [31:0] addr; logic [1:0] size; logic [31:0] wdata;
    logic [31:0] srdata; logic [1:0] resp; int awd; int wd; int bd; int hold;
    bit issue; logic [31:0] e_wdata; logic [3:0] e_strb; logic [31:0] e_rdata;
    bit e_err; int lat;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // awd delays AW/AR ready, wd delays W ready, bd delays B/R after the address/data phase (-1 = never)
  task automatic run(input vec_t v, input bit exp_rdy);
    int k, awc, wc, arc, bc, rc, kb;
    bit got, anyv;
    logic [31:0] c_awaddr, c_wdata, c_araddr;
    logic [3:0] c_strb;
    logic [2:0] c_prot;
    @(negedge clk);
    chk("req_ready", ready_and_o, 1);
    v_i = 1; addr_i = v.addr; wr_en_i = v.wr; data_size_i = v.size; wdata_i = v.wdata;
    m_axil_rdata = v.srdata; m_axil_bresp = v.resp; m_axil_rresp = v.resp;
    k = 0; awc = 0; wc = 0; arc = 0; bc = 0; rc = 0; kb = -1; got = 0; anyv = 0;
    c_awaddr = 0; c_wdata = 0; c_araddr = 0; c_strb = 0; c_prot = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      v_i = 0;
      anyv |= m_axil_awvalid | m_axil_wvalid | m_axil_arvalid;
      if (v_o) got = 1;
      else begin
        m_axil_awready_i = k > v.awd;
        m_axil_arready_i = k > v.awd;
        m_axil_wready_i = k > v.wd;
        if (m_axil_awvalid && m_axil_awready_i) begin awc++; c_awaddr = m_axil_awaddr; c_prot |= m_axil_awprot; end
        if (m_axil_wvalid && m_axil_wready_i) begin wc++; c_wdata = m_axil_wdata; c_strb = m_axil_wstrb; end
        if (m_axil_arvalid && m_axil_arready_i) begin arc++; c_araddr = m_axil_araddr; c_prot |= m_axil_arprot; end
        m_axil_bvalid = v.wr && kb >= 0 && v.bd >= 0 && k > kb + v.bd;
        m_axil_rvalid = !v.wr && kb >= 0 && v.bd >= 0 && k > kb + v.bd;
        if (m_axil_bvalid && m_axil_bready_o) bc++;
        if (m_axil_rvalid && m_axil_rready_o) rc++;
        if (kb < 0 && ((v.wr && awc > 0 && wc > 0) || (!v.wr && arc > 0))) kb = k;
      end
    end
    m_axil_awready_i = 0; m_axil_wready_i = 0; m_axil_arready_i = 0;
    m_axil_bvalid = 0; m_axil_rvalid = 0;
    chk("resp_seen", got, 1);
    chk("latency", k, v.lat);
    chk("rdata", rdata_o, v.e_rdata);
    chk("err", err_o, v.e_err);
    chk("any_valid", anyv, v.issue);
    chk("aw_count", awc, v.issue && v.wr);
    chk("w_count", wc, v.issue && v.wr);
    chk("ar_count", arc, v.issue && !v.wr);
    if (v.bd >= 0) chk("br_count", bc + rc, v.issue);
    if (v.issue && v.wr) begin
      chk("awaddr", c_awaddr, v.addr);
      chk("wdata", c_wdata, v.e_wdata);
      chk("wstrb", c_strb, v.e_strb);
    end
    if (v.issue && !v.wr) chk("araddr", c_araddr, v.addr);
    if (v.issue) chk("prot", c_prot, 0);
    if (v.hold > 0) begin
      ready_and_i = 0;
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        chk("hold_v", v_o, 1);
        chk("hold_rdata", rdata_o, v.e_rdata);
        chk("hold_err", err_o, v.e_err);
      end
      ready_and_i = 1;
    end
    @(negedge clk);
    chk("ack_v", v_o, 0);
    chk("ack_ready", ready_and_o, exp_rdy);
  endtask

  initial begin
    //         wr addr       sz wdata          srdata         resp  awd wd bd hold iss e_wdata        strb  e_rdata        err lat
    tbl[0]  = '{1, 32'h100, 2, 32'hDEADBEEF, 32'h0,         2'b00, 0, 0, 0, 0, 1, 32'hDEADBEEF, 4'hF, 32'h0,         0, 3};
    tbl[1]  = '{1, 32'h103, 0, 32'h123456A5, 32'h0,         2'b00, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 4'h8, 32'h0,         0, 3};
    tbl[2]  = '{0, 32'h102, 1, 32'h0,        32'h1234ABCD, 2'b00, 0, 0, 0, 0, 1, 32'h0,        4'h0, 32'h00001234, 0, 3};
    tbl[3]  = '{1, 32'h0F1, 0, 32'h0000003C, 32'h0,         2'b00, 0, 0, 0, 0, 1, 32'h3C3C3C3C, 4'h2, 32'h0,         0, 3};
    tbl[4]  = '{1, 32'h002, 1, 32'h0000BEEF, 32'h0,         2'b00, 0, 0, 0, 0, 1, 32'hBEEFBEEF, 4'hC, 32'h0,         0, 3};
    tbl[5]  = '{0, 32'h201, 0, 32'h0,        32'h11223344, 2'b00, 0, 0, 0, 0, 1, 32'h0,        4'h0, 32'h00000033, 0, 3};
    tbl[6]  = '{0, 32'h010, 2, 32'h0,        32'hCAFEF00D, 2'b10, 0, 0, 0, 4, 1, 32'h0,        4'h0, 32'hCAFEF00D, 1, 3};
    tbl[7]  = '{1, 32'h020, 2, 32'h01020304, 32'h0,         2'b11, 0, 0, 0, 0, 1, 32'h01020304, 4'hF, 32'h0,         1, 3};
    tbl[8]  = '{1, 32'h040, 2, 32'h55AA55AA, 32'h0,         2'b00, 0, 2, 5, 0, 1, 32'h55AA55AA, 4'hF, 32'h0,         0, 10};
    tbl[9]  = '{1, 32'h101, 2, 32'h11111111, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,        4'h0, 32'h0,         1, 1};
    tbl[10] = '{0, 32'h200, 3, 32'h0,        32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,        4'h0, 32'h0,         1, 1};
    tbl[11] = '{0, 32'h001, 1, 32'h0,        32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,        4'h0, 32'h0,         1, 1};
    tbl[12] = '{0, 32'h300, 2, 32'h0,        32'h89ABCDEF, 2'b00, 3, 0, 2, 0, 1, 32'h0,        4'h0, 32'h89ABCDEF, 0, 8};
    tbl[13] = '{1, 32'h000, 2, 32'hF00DCAFE, 32'h0,         2'b00, 3, 0, 0, 0, 1, 32'hF00DCAFE, 4'hF, 32'h0,         0, 6};
    tbl[14] = '{0, 32'h003, 0, 32'h0,        32'hAABBCCDD, 2'b00, 0, 0, 0, 0, 1, 32'h0,        4'h0, 32'h000000AA, 0, 3};

    repeat (3) @(negedge clk);
    chk("rst_ready", ready_and_o, 0);
    chk("rst_v", v_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 0);
    chk("rst_readys", {m_axil_bready_o, m_axil_rready_o}, 0);
    reset_i = 0;
    @(negedge clk);
    chk("post_rst_ready", ready_and_o, 1);

    for (int i = 0; i < 15; i++) run(tbl[i], 1);

    // reset while a write is stuck in SEND
    @(negedge clk);
    v_i = 1; wr_en_i = 1; addr_i = 32'h80; data_size_i = 2; wdata_i = 32'h1;
    @(negedge clk);
    v_i = 0;
    chk("mid_awvalid", m_axil_awvalid, 1);
    @(negedge clk);
    reset_i = 1;
    @(negedge clk);
    chk("mid_rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 0);
    chk("mid_rst_ready", ready_and_o, 0);
    chk("mid_rst_v", v_o, 0);
    reset_i = 0;
    @(negedge clk);
    chk("mid_post_ready", ready_and_o, 1);
    run(tbl[0], 1);

`ifdef AXIL_MMIO_MASTER_TIMEOUT_EN
    begin
      vec_t t;
      t = '{1, 32'h500, 2, 32'h00000077, 32'h0, 2'b00, 0, 0, -1, 0, 1, 32'h00000077, 4'hF, 32'h0, 1, 18};
      run(t, 0);
      repeat (3) begin
        @(negedge clk);
        chk("stale_ready", ready_and_o, 0);
        chk("stale_bready", m_axil_bready_o, 1);
      end
      m_axil_bvalid = 1;
      @(negedge clk);
      m_axil_bvalid = 0;
      chk("stale_clear", ready_and_o, 1);
      run(tbl[1], 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
